// File: rtl/irq_ctrl.sv
// Interrupt controller: latches/masks N_SRC peripheral IRQ lines, picks the lowest-index
// active source and runs a REQ -> INTACK -> EOI handshake with the CPU.
module irq_ctrl #(
  parameter int N_SRC = 6
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic [3:2]       ADD_I,
  input  logic             WE_I,
  input  logic [31:0]      DAT_I,
  output logic [31:0]      DAT_O,
  input  logic [N_SRC-1:0] HWINT,
  input  logic             INTACK,
  output logic             IRQ,
  output logic [2:0]       VEC
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] A_CTRL = 2'b00;
  localparam logic [1:0] A_PEND = 2'b01;
  localparam logic [1:0] A_STAT = 2'b10;
  localparam logic [1:0] A_MODE = 2'b11;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] prev_q;
  logic             ie_q, ie_d;
  logic [2:0]       vec_q, vec_d;

  logic             wr_ctrl, wr_pend, wr_stat, wr_mode;
  logic [N_SRC-1:0] active;
  logic [7:0]       active_w;
  logic             any_active;
  logic [2:0]       sel;
  logic             in_service;
  logic             unused_dat;

  assign wr_ctrl    = WE_I && (ADD_I == A_CTRL);
  assign wr_pend    = WE_I && (ADD_I == A_PEND);
  assign wr_stat    = WE_I && (ADD_I == A_STAT);
  assign wr_mode    = WE_I && (ADD_I == A_MODE);
  assign unused_dat = ^DAT_I;

  assign active     = pend_q & mask_q;
  assign any_active = |active;

  always_comb begin
    active_w = '0;
    active_w[N_SRC-1:0] = active;
  end

  always_comb begin
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) sel = 3'(i);
    end
  end

  // A source whose mode is being rewritten this cycle keeps its pending bit as-is.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (wr_mode && (DAT_I[i] != mode_q[i])) begin
        pend_d[i] = pend_q[i];
      end else if (!mode_q[i]) begin
        pend_d[i] = HWINT[i];
      end else begin
        pend_d[i] = (HWINT[i] & ~prev_q[i]) | (pend_q[i] & ~(wr_pend & DAT_I[i]));
      end
    end
  end

  always_comb begin
    mask_d = mask_q;
    ie_d   = ie_q;
    mode_d = mode_q;
    if (wr_ctrl) begin
      mask_d = DAT_I[N_SRC-1:0];
      ie_d   = DAT_I[8];
    end
    if (wr_mode) begin
      mode_d = DAT_I[N_SRC-1:0];
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      mode_q  <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
      ie_q    <= 1'b0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      prev_q  <= HWINT;
      ie_q    <= ie_d;
      vec_q   <= vec_d;
    end
  end

  // vec is only loaded on IDLE->REQ so it stays frozen through REQ and SERVICE.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      S_IDLE: begin
        if (ie_q && any_active) begin
          state_d = S_REQ;
          vec_d   = sel;
        end
      end
      S_REQ: begin
        if (!ie_q || !active_w[vec_q]) begin
          state_d = S_IDLE;
        end else if (INTACK) begin
          state_d = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (wr_stat) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    IRQ        = (state_q == S_REQ);
    in_service = (state_q == S_SERVICE);
    VEC        = vec_q;
  end

  always_comb begin
    DAT_O = '0;
    case (ADD_I)
      A_CTRL: begin
        DAT_O[N_SRC-1:0] = mask_q;
        DAT_O[8]         = ie_q;
      end
      A_PEND: DAT_O[N_SRC-1:0] = pend_q;
      A_STAT: begin
        DAT_O[2:0] = vec_q;
        DAT_O[30]  = IRQ;
        DAT_O[31]  = in_service;
      end
      A_MODE: DAT_O[N_SRC-1:0] = mode_q;
      default: DAT_O = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus random traffic checked every cycle
// against a cycle-level behavioural model of the register map and handshake.
module tb_irq_ctrl;

  localparam int N_SRC = 6;
  localparam bit [7:0] SRC_MASK = 8'((1 << N_SRC) - 1);

  logic             CLK_I;
  logic             RST_I;
  logic [3:2]       ADD_I;
  logic             WE_I;
  logic [31:0]      DAT_I;
  logic [31:0]      DAT_O;
  logic [N_SRC-1:0] HWINT;
  logic             INTACK;
  logic             IRQ;
  logic [2:0]       VEC;

  int n_checks = 0;
  int n_errors = 0;

  irq_ctrl #(.N_SRC(N_SRC)) dut (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .ADD_I  (ADD_I),
    .WE_I   (WE_I),
    .DAT_I  (DAT_I),
    .DAT_O  (DAT_O),
    .HWINT  (HWINT),
    .INTACK (INTACK),
    .IRQ    (IRQ),
    .VEC    (VEC)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  // Reference state: registers as plain bytes, handshake as two flags.
  bit [7:0] m_mask, m_mode, m_pend, m_prev;
  bit       m_ie, m_req, m_svc;
  bit [2:0] m_vec;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r = {23'd0, m_ie, m_mask};
      2'd1: r = {24'd0, m_pend};
      2'd2: r = {m_svc, m_req, 27'd0, m_vec};
      default: r = {24'd0, m_mode};
    endcase
    return r;
  endfunction

  task automatic tick();
    bit [7:0] n_mask, n_mode, n_pend, n_prev, act, d8;
    bit       n_ie, n_req, n_svc;
    bit [2:0] n_vec;
    int       first;
    n_mask = m_mask; n_mode = m_mode; n_pend = m_pend; n_ie = m_ie;
    n_req  = m_req;  n_svc  = m_svc;  n_vec  = m_vec;
    n_prev = 8'(HWINT);
    d8     = DAT_I[7:0];
    if (RST_I) begin
      n_mask = 0; n_mode = 0; n_pend = 0; n_prev = 0; n_ie = 0;
      n_req  = 0; n_svc  = 0; n_vec  = 0;
    end else begin
      if (WE_I && ADD_I == 2'd0) begin
        n_mask = d8 & SRC_MASK;
        n_ie   = DAT_I[8];
      end
      if (WE_I && ADD_I == 2'd3) n_mode = d8 & SRC_MASK;
      for (int i = 0; i < N_SRC; i++) begin
        if (WE_I && ADD_I == 2'd3 && d8[i] != m_mode[i]) n_pend[i] = m_pend[i];
        else if (!m_mode[i]) n_pend[i] = HWINT[i];
        else if (HWINT[i] && !m_prev[i]) n_pend[i] = 1'b1;
        else if (WE_I && ADD_I == 2'd1 && d8[i]) n_pend[i] = 1'b0;
      end
      act   = m_pend & m_mask;
      first = -1;
      for (int i = N_SRC - 1; i >= 0; i--) if (act[i]) first = i;
      if (m_svc) begin
        if (WE_I && ADD_I == 2'd2) n_svc = 0;
      end else if (m_req) begin
        if (!m_ie || !act[m_vec]) n_req = 0;
        else if (INTACK) begin n_req = 0; n_svc = 1; end
      end else if (m_ie && first >= 0) begin
        n_req = 1;
        n_vec = 3'(first);
      end
    end
    @(posedge CLK_I);
    m_mask = n_mask; m_mode = n_mode; m_pend = n_pend; m_prev = n_prev;
    m_ie = n_ie; m_req = n_req; m_svc = n_svc; m_vec = n_vec;
    #1;
    check_val("irq", {31'd0, IRQ}, {31'd0, m_req});
    check_val("vec", {29'd0, VEC}, {29'd0, m_vec});
    check_val("dat_o", DAT_O, model_rd(ADD_I));
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    WE_I  = 1'b1;
    ADD_I = a;
    DAT_I = d;
    tick();
    WE_I  = 1'b0;
    DAT_I = '0;
  endtask

  task automatic rd_expect(input string tag, input logic [1:0] a, input logic [31:0] exp);
    ADD_I = a;
    #1;
    check_val(tag, DAT_O, exp);
  endtask

  task automatic pulse_ack();
    INTACK = 1'b1;
    tick();
    INTACK = 1'b0;
  endtask

  initial begin
    RST_I = 1'b1; ADD_I = '0; WE_I = 1'b0; DAT_I = '0; HWINT = '0; INTACK = 1'b0;
    m_mask = 0; m_mode = 0; m_pend = 0; m_prev = 0; m_ie = 0; m_req = 0; m_svc = 0; m_vec = 0;

    // 1: reset state, level source 2
    tick();
    RST_I = 1'b0;
    check_val("rst_irq", {31'd0, IRQ}, 32'd0);
    check_val("rst_vec", {29'd0, VEC}, 32'd0);
    for (int a = 0; a < 4; a++) rd_expect("rst_reg", 2'(a), 32'd0);
    bus_wr(2'd0, 32'h13F);
    bus_wr(2'd3, 32'h00);
    HWINT = 6'b000100;
    tick();
    check_val("lat_k_irq", {31'd0, IRQ}, 32'd0);
    tick();
    check_val("lat_k1_irq", {31'd0, IRQ}, 32'd1);
    check_val("lat_vec", {29'd0, VEC}, 32'd2);
    rd_expect("req_stat", 2'd2, 32'h4000_0002);
    pulse_ack();
    HWINT = '0;
    bus_wr(2'd2, 32'd0);
    tick();

    // 2: edge source 3
    bus_wr(2'd3, 32'h08);
    HWINT = 6'b001000;
    tick();
    HWINT = '0;
    rd_expect("edge_pend", 2'd1, 32'h08);
    tick();
    rd_expect("edge_req", 2'd2, 32'h4000_0003);
    pulse_ack();
    rd_expect("edge_svc", 2'd2, 32'h8000_0003);
    check_val("svc_irq", {31'd0, IRQ}, 32'd0);
    bus_wr(2'd1, 32'h08);
    bus_wr(2'd2, 32'h00);
    tick();
    check_val("eoi_irq", {31'd0, IRQ}, 32'd0);

    // 3: priority and frozen vector
    HWINT = 6'b010010;
    tick(); tick();
    check_val("prio_vec", {29'd0, VEC}, 32'd1);
    HWINT = 6'b010011;
    tick(); tick();
    check_val("frozen_vec", {29'd0, VEC}, 32'd1);
    pulse_ack();
    bus_wr(2'd2, 32'd0);
    tick();
    check_val("rearb_vec", {29'd0, VEC}, 32'd0);
    check_val("rearb_irq", {31'd0, IRQ}, 32'd1);
    pulse_ack();
    HWINT = '0;
    bus_wr(2'd2, 32'd0);
    tick();

    // 4: level withdrawal
    HWINT = 6'b100000;
    tick(); tick();
    check_val("wd_req_vec", {29'd0, VEC}, 32'd5);
    HWINT = '0;
    tick(); tick();
    check_val("wd_irq", {31'd0, IRQ}, 32'd0);
    rd_expect("wd_stat", 2'd2, 32'h0000_0005);

    // 5: set beats clear on edge source 0
    bus_wr(2'd3, 32'h09);
    HWINT = 6'b000001;
    bus_wr(2'd1, 32'h01);
    rd_expect("race_pend", 2'd1, 32'h01);
    tick();
    bus_wr(2'd1, 32'h01);
    tick();
    check_val("swclr_irq", {31'd0, IRQ}, 32'd0);
    HWINT = '0;
    tick();

    // 6: masking, then reset out of SERVICE
    bus_wr(2'd0, 32'h100);
    bus_wr(2'd3, 32'h00);
    HWINT = 6'h3F;
    tick(); tick(); tick();
    check_val("mask_irq", {31'd0, IRQ}, 32'd0);
    rd_expect("mask_pend", 2'd1, 32'h3F);
    bus_wr(2'd0, 32'h13F);
    check_val("ctrl_old_irq", {31'd0, IRQ}, 32'd0);
    tick();
    pulse_ack();
    rd_expect("pre_rst_stat", 2'd2, 32'h8000_0000);
    RST_I = 1'b1;
    tick();
    RST_I = 1'b0;
    check_val("rst2_irq", {31'd0, IRQ}, 32'd0);
    rd_expect("rst2_ctrl", 2'd0, 32'd0);
    rd_expect("rst2_stat", 2'd2, 32'd0);
    rd_expect("rst2_pend", 2'd1, 32'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) HWINT = N_SRC'($urandom);
      INTACK = ($urandom_range(0, 3) == 0);
      RST_I  = ($urandom_range(0, 499) == 0);
      WE_I   = ($urandom_range(0, 5) == 0);
      ADD_I  = 2'($urandom);
      DAT_I  = $urandom;
      if (WE_I && ADD_I == 2'd0 && $urandom_range(0, 3) != 0) DAT_I[8] = 1'b1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
